// File: rtl/lfsr_period_monitor.sv
// Measures the period of an LFSR sequence bus and flags zero lockup, stall or timeout.
// Optional `maximal` output is enabled by defining LFSR_PERIOD_MONITOR_MAXIMAL_EN.
module lfsr_period_monitor #(
  parameter int LARGURA    = 8,
  parameter int CONT_W     = 16,
  parameter int MAX_CICLOS = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] sequencia,
  input  logic               iniciar,
  input  logic               ack,
  output logic [CONT_W-1:0]  periodo,
  output logic [1:0]         erro,
  output logic               valido,
  output logic               ocupado
`ifdef LFSR_PERIOD_MONITOR_MAXIMAL_EN
  ,
  output logic               maximal
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ZERO    = 2'b01;
  localparam logic [1:0] ERR_STALL   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [CONT_W-1:0] LIMITE = CONT_W'(MAX_CICLOS);

  logic [1:0]         estado_q, estado_d;
  logic [LARGURA-1:0] referencia_q, referencia_d;
  logic [LARGURA-1:0] anterior_q, anterior_d;
  logic [CONT_W-1:0]  contador_q, contador_d;
  logic [CONT_W-1:0]  periodo_q, periodo_d;
  logic [1:0]         erro_q, erro_d;
  logic               valido_q, valido_d;
  logic               ocupado_q, ocupado_d;
  logic [CONT_W-1:0]  passo_s;
  logic               fim_s;
  logic [1:0]         codigo_s;
`ifdef LFSR_PERIOD_MONITOR_MAXIMAL_EN
  localparam logic [CONT_W-1:0] PERIODO_MAX = CONT_W'((2 ** LARGURA) - 1);
  logic maximal_q, maximal_d;
`endif

  // Termination tests in priority order: zero, stall, reference match, timeout.
  always_comb begin
    passo_s  = contador_q + {{(CONT_W-1){1'b0}}, 1'b1};
    fim_s    = 1'b1;
    codigo_s = ERR_OK;
    if (sequencia == {LARGURA{1'b0}}) begin
      codigo_s = ERR_ZERO;
    end else if (sequencia == anterior_q) begin
      codigo_s = ERR_STALL;
    end else if (sequencia == referencia_q) begin
      codigo_s = ERR_OK;
    end else if (passo_s == LIMITE) begin
      codigo_s = ERR_TIMEOUT;
    end else begin
      fim_s = 1'b0;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    estado_d     = estado_q;
    referencia_d = referencia_q;
    anterior_d   = anterior_q;
    contador_d   = contador_q;
    periodo_d    = periodo_q;
    erro_d       = erro_q;
`ifdef LFSR_PERIOD_MONITOR_MAXIMAL_EN
    maximal_d    = maximal_q;
`endif
    case (estado_q)
      ST_IDLE: begin
        if (iniciar) begin
          referencia_d = sequencia;
          anterior_d   = sequencia;
          contador_d   = {CONT_W{1'b0}};
          estado_d     = ST_COUNT;
        end else begin
          estado_d = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (fim_s) begin
          periodo_d = passo_s;
          erro_d    = codigo_s;
          estado_d  = ST_DONE;
`ifdef LFSR_PERIOD_MONITOR_MAXIMAL_EN
          maximal_d = (codigo_s == ERR_OK) && (passo_s == PERIODO_MAX);
`endif
        end else begin
          contador_d = passo_s;
          anterior_d = sequencia;
        end
      end
      ST_DONE: begin
        if (ack) begin
          estado_d = ST_IDLE;
`ifdef LFSR_PERIOD_MONITOR_MAXIMAL_EN
          maximal_d = 1'b0;
`endif
        end else begin
          estado_d = ST_DONE;
        end
      end
      default: begin
        estado_d = ST_IDLE;
      end
    endcase
    valido_d  = (estado_d == ST_DONE);
    ocupado_d = (estado_d == ST_COUNT);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q     <= ST_IDLE;
      referencia_q <= {LARGURA{1'b0}};
      anterior_q   <= {LARGURA{1'b0}};
      contador_q   <= {CONT_W{1'b0}};
      periodo_q    <= {CONT_W{1'b0}};
      erro_q       <= ERR_OK;
      valido_q     <= 1'b0;
      ocupado_q    <= 1'b0;
`ifdef LFSR_PERIOD_MONITOR_MAXIMAL_EN
      maximal_q    <= 1'b0;
`endif
    end else begin
      estado_q     <= estado_d;
      referencia_q <= referencia_d;
      anterior_q   <= anterior_d;
      contador_q   <= contador_d;
      periodo_q    <= periodo_d;
      erro_q       <= erro_d;
      valido_q     <= valido_d;
      ocupado_q    <= ocupado_d;
`ifdef LFSR_PERIOD_MONITOR_MAXIMAL_EN
      maximal_q    <= maximal_d;
`endif
    end
  end

  assign periodo = periodo_q;
  assign erro    = erro_q;
  assign valido  = valido_q;
  assign ocupado = ocupado_q;
`ifdef LFSR_PERIOD_MONITOR_MAXIMAL_EN
  assign maximal = maximal_q;
`endif

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Self-checking bench for lfsr_period_monitor: randomized sequences checked against a sequence-scan model.
module tb_lfsr_period_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  sequencia;
  logic        iniciar_a, ack_a, iniciar_b, ack_b;
  logic [15:0] periodo_a, periodo_b;
  logic [1:0]  erro_a, erro_b;
  logic        valido_a, valido_b, ocupado_a, ocupado_b;
`ifdef LFSR_PERIOD_MONITOR_MAXIMAL_EN
  logic        maximal_a, maximal_b;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] seq_buf [0:2047];

  always #5 clock = ~clock;

  lfsr_period_monitor dut_a (
    .clock(clock), .reset(reset), .sequencia(sequencia), .iniciar(iniciar_a), .ack(ack_a),
    .periodo(periodo_a), .erro(erro_a), .valido(valido_a), .ocupado(ocupado_a)
`ifdef LFSR_PERIOD_MONITOR_MAXIMAL_EN
    , .maximal(maximal_a)
`endif
  );

  lfsr_period_monitor #(.MAX_CICLOS(16)) dut_b (
    .clock(clock), .reset(reset), .sequencia(sequencia), .iniciar(iniciar_b), .ack(ack_b),
    .periodo(periodo_b), .erro(erro_b), .valido(valido_b), .ocupado(ocupado_b)
`ifdef LFSR_PERIOD_MONITOR_MAXIMAL_EN
    , .maximal(maximal_b)
`endif
  );

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Reference: scan the stimulus for the first step that ends the measurement.
  function automatic void model(input int max_c, output int exp_p, output logic [1:0] exp_e);
    exp_p = -1;
    exp_e = 2'b00;
    for (int k = 1; k < 2048; k++) begin
      if (seq_buf[k] == 8'h00) begin exp_p = k; exp_e = 2'b01; break; end
      if (seq_buf[k] == seq_buf[k-1]) begin exp_p = k; exp_e = 2'b10; break; end
      if (seq_buf[k] == seq_buf[0]) begin exp_p = k; exp_e = 2'b00; break; end
      if (k == max_c) begin exp_p = k; exp_e = 2'b11; break; end
    end
  endfunction

  task automatic fill_lfsr(input logic [7:0] seed);
    seq_buf[0] = seed;
    for (int k = 1; k < 2048; k++) seq_buf[k] = lfsr_next(seq_buf[k-1]);
  endtask

  // Start a measurement and step the buffer until valido rises or the budget runs out.
  task automatic run_measure(input bit use_b, input int budget, output int edges,
                             output bit done_seen, output int busy_bad);
    edges = 0; done_seen = 1'b0; busy_bad = 0;
    sequencia = seq_buf[0];
    if (use_b) iniciar_b = 1'b1; else iniciar_a = 1'b1;
    @(posedge clock); #1;
    iniciar_a = 1'b0; iniciar_b = 1'b0;
    while (!done_seen && edges < budget) begin
      sequencia = seq_buf[edges + 1];
      @(posedge clock); #1;
      edges++;
      if (use_b ? valido_b : valido_a) done_seen = 1'b1;
      else if (!(use_b ? ocupado_b : ocupado_a)) busy_bad++;
    end
  endtask

  task automatic pulse_ack(input bit use_b);
    if (use_b) ack_b = 1'b1; else ack_a = 1'b1;
    @(posedge clock); #1;
    ack_a = 1'b0; ack_b = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({valido_a, ocupado_a, erro_a, periodo_a} !== 20'h0) begin
      failures++;
      $display("FAIL reset_a: got v=%b o=%b e=%b p=%0d, want all 0", valido_a, ocupado_a, erro_a, periodo_a);
    end
    checks++;
    if ({valido_b, ocupado_b, erro_b, periodo_b} !== 20'h0) begin
      failures++;
      $display("FAIL reset_b: got v=%b o=%b e=%b p=%0d, want all 0", valido_b, ocupado_b, erro_b, periodo_b);
    end
  endtask

  task automatic check_result(input string nome, input bit use_b, input int max_c);
    int edges, busy_bad, exp_p;
    bit done_seen;
    logic [1:0] exp_e;
    model(max_c, exp_p, exp_e);
    run_measure(use_b, max_c + 4, edges, done_seen, busy_bad);
    checks++;
    if (!done_seen || edges !== exp_p) begin
      failures++;
      $display("FAIL %s_latency: got done=%0d edges=%0d, want edges=%0d", nome, done_seen, edges, exp_p);
    end
    checks++;
    if ((use_b ? periodo_b : periodo_a) !== 16'(exp_p) || (use_b ? erro_b : erro_a) !== exp_e) begin
      failures++;
      $display("FAIL %s_result: got p=%0d e=%b, want p=%0d e=%b", nome,
               use_b ? periodo_b : periodo_a, use_b ? erro_b : erro_a, exp_p, exp_e);
    end
    checks++;
    if (busy_bad !== 0 || (use_b ? ocupado_b : ocupado_a) !== 1'b0) begin
      failures++;
      $display("FAIL %s_ocupado: got busy_gaps=%0d ocupado_in_done=%b, want 0 0", nome, busy_bad,
               use_b ? ocupado_b : ocupado_a);
    end
`ifdef LFSR_PERIOD_MONITOR_MAXIMAL_EN
    checks++;
    if ((use_b ? maximal_b : maximal_a) !== (exp_e == 2'b00 && exp_p == 255)) begin
      failures++;
      $display("FAIL %s_maximal: got %b, want %b", nome, use_b ? maximal_b : maximal_a,
               (exp_e == 2'b00 && exp_p == 255));
    end
`endif
    pulse_ack(use_b);
    checks++;
    if ((use_b ? valido_b : valido_a) !== 1'b0) begin
      failures++;
      $display("FAIL %s_ack: got valido=%b, want 0", nome, use_b ? valido_b : valido_a);
    end
  endtask

  task automatic test_maximal;
    int edges, busy_bad;
    bit done_seen;
    fill_lfsr(8'h01);
    check_result("maximal_seed01", 1'b0, 1024);
    for (int i = 0; i < 3; i++) begin
      fill_lfsr(8'($urandom_range(1, 255)));
      check_result("maximal_rand", 1'b0, 1024);
    end
    fill_lfsr(8'h01);
    run_measure(1'b0, 300, edges, done_seen, busy_bad);
    checks++;
    if (periodo_a !== 16'd255 || erro_a !== 2'b00) begin
      failures++;
      $display("FAIL maximal_255: got p=%0d e=%b, want p=255 e=00", periodo_a, erro_a);
    end
    pulse_ack(1'b0);
  endtask

  task automatic test_stalled;
    for (int k = 0; k < 2048; k++) seq_buf[k] = 8'hA5;
    check_result("stalled", 1'b0, 1024);
  endtask

  task automatic test_zero_lockup;
    fill_lfsr(8'h01);
    for (int k = 3; k < 2048; k++) seq_buf[k] = 8'h00;
    check_result("zero_lockup", 1'b0, 1024);
    for (int k = 0; k < 2048; k++) seq_buf[k] = 8'h00;
    check_result("zero_reference", 1'b0, 1024);
  endtask

  task automatic test_timeout;
    for (int k = 0; k < 2048; k++) seq_buf[k] = 8'(8'h10 + k);
    check_result("timeout", 1'b1, 16);
    for (int i = 0; i < 6; i++) begin
      seq_buf[0] = 8'($urandom_range(0, 255));
      for (int k = 1; k < 2048; k++) seq_buf[k] = 8'($urandom_range(0, 255));
      check_result("timeout_rand", 1'b1, 16);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 2048; k++) seq_buf[k] = 8'($urandom_range(0, 7));
      check_result("random", 1'b0, 1024);
    end
  endtask

  task automatic test_handshake;
    int edges, busy_bad, bad;
    bit done_seen;
    for (int k = 0; k < 2048; k++) seq_buf[k] = 8'h3C;
    run_measure(1'b0, 8, edges, done_seen, busy_bad);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      iniciar_a = 1'b1;
      sequencia = 8'($urandom_range(0, 255));
      @(posedge clock); #1;
      if (valido_a !== 1'b1 || periodo_a !== 16'd1 || erro_a !== 2'b10 || ocupado_a !== 1'b0) bad++;
    end
    checks++;
    if (!done_seen || bad !== 0) begin
      failures++;
      $display("FAIL handshake_hold: got done=%0d unstable_cycles=%0d, want 1 0", done_seen, bad);
    end
    ack_a = 1'b1;
    @(posedge clock); #1;
    ack_a = 1'b0;
    checks++;
    if (valido_a !== 1'b0 || ocupado_a !== 1'b0) begin
      failures++;
      $display("FAIL handshake_ack: got v=%b o=%b, want 0 0", valido_a, ocupado_a);
    end
    iniciar_a = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (ocupado_a !== 1'b0 || valido_a !== 1'b0 || periodo_a !== 16'd1) begin
      failures++;
      $display("FAIL handshake_idle: got o=%b v=%b p=%0d, want 0 0 1", ocupado_a, valido_a, periodo_a);
    end
  endtask

  task automatic test_reset_mid_count;
    fill_lfsr(8'h01);
    sequencia = seq_buf[0];
    iniciar_a = 1'b1;
    @(posedge clock); #1;
    iniciar_a = 1'b0;
    for (int k = 1; k < 100; k++) begin
      sequencia = seq_buf[k];
      @(posedge clock); #1;
    end
    checks++;
    if (ocupado_a !== 1'b1) begin
      failures++;
      $display("FAIL midcount_busy: got ocupado=%b, want 1", ocupado_a);
    end
    reset = 1'b0;
    iniciar_a = 1'b1;
    ack_a = 1'b1;
    repeat (2) begin
      @(posedge clock); #1;
    end
    checks++;
    if ({valido_a, ocupado_a, erro_a, periodo_a} !== 20'h0) begin
      failures++;
      $display("FAIL midcount_reset: got v=%b o=%b e=%b p=%0d, want all 0", valido_a, ocupado_a, erro_a, periodo_a);
    end
    reset = 1'b1;
    iniciar_a = 1'b0;
    ack_a = 1'b0;
    @(posedge clock); #1;
    fill_lfsr(8'(lfsr_next(8'h01)));
    check_result("after_reset", 1'b0, 1024);
  endtask

  initial begin
    reset = 1'b0;
    sequencia = 8'h00;
    iniciar_a = 1'b0; ack_a = 1'b0; iniciar_b = 1'b0; ack_b = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    test_reset;
    reset = 1'b1;
    @(posedge clock); #1;
    test_maximal;
    test_stalled;
    test_zero_lockup;
    test_timeout;
    test_random;
    test_handshake;
    test_reset_mid_count;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_period_monitor.md
Name: lfsr_period_monitor

Overview:
Downstream consumer of the 8-bit LFSR output bus `sequencia`. On request it captures one LFSR state and counts clocks until that state reappears, giving the sequence period. It also flags an all-zero lockup, a stalled register, or a timeout. The result is presented with a valid/ack handshake to the test or control logic.

Parameters:
LARGURA, 8, width of the monitored sequence bus
CONT_W, 16, width of the period counter and `periodo` output
MAX_CICLOS, 1024, timeout in count steps; must satisfy 1 <= MAX_CICLOS <= 2^CONT_W-1

Ports:
clock  input  1  single clock; all state changes on its rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
sequencia  input  LARGURA  LFSR state, one new value per clock
iniciar  input  1  start request; sampled only in IDLE
ack  input  1  result acknowledge; sampled only in DONE
periodo  output  CONT_W  measured step count, registered
erro  output  2  00 ok, 01 zero lockup, 10 stalled, 11 timeout
valido  output  1  result valid; high exactly while in DONE
ocupado  output  1  high while in COUNT

Behaviour:
- Reset: reset=0 at a rising edge → state IDLE, periodo=0, erro=00, valido=0, ocupado=0, internal referencia/anterior/contador=0. Reset has priority over all inputs in every state, including mid-COUNT.
- States: IDLE, COUNT, DONE. Encoding is free.
- IDLE:
  - On iniciar=1: referencia<=sequencia, anterior<=sequencia, contador<=0, go to COUNT.
  - Otherwise hold. ack is ignored.
- COUNT: on each edge, let n=contador+1 (CONT_W bits) and test the current sequencia in this priority order:
  1. sequencia==0 → erro<=01
  2. sequencia==anterior → erro<=10
  3. sequencia==referencia → erro<=00
  4. n==MAX_CICLOS → erro<=11
- COUNT, terminating edge: if any test above fires, periodo<=n and go to DONE.
- COUNT, otherwise: contador<=n, anterior<=sequencia. iniciar and ack are ignored.
- Overflow: the counter cannot wrap, because the timeout fires first.
- DONE:
  - valido=1; periodo and erro hold stable.
  - On ack=1 → IDLE; valido drops on that edge.
  - iniciar is ignored.
  - If iniciar and ack are both high, only ack acts; a new start needs iniciar in IDLE.
- Latency:
  - For an LFSR stepping every clock with period P <= MAX_CICLOS, the edge entering DONE is the P-th edge after the start edge.
  - valido is visible after that edge.
- Outputs: ocupado=1 exactly in COUNT. periodo and erro are updated only on the edge entering DONE and on reset.
- Reference value zero: a zero reference is reported as erro=01 on the first COUNT edge, periodo=1.

Optional Feature:
Macro LFSR_PERIOD_MONITOR_MAXIMAL_EN.
- Defined: adds output port `maximal` (1 bit), registered, updated with periodo.
  - maximal=1 iff erro=00 and periodo == 2^LARGURA-1.
  - Cleared by reset and on the edge leaving DONE.
- Not defined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Maximal LFSR: drive sequencia from a model of polynomial x^8+x^6+x^5+x^4+1 seeded 0x01; pulse iniciar one cycle in IDLE → ocupado for 255 edges, then valido=1, periodo=255, erro=00 (maximal=1 if enabled).
- Stalled register: hold sequencia=0xA5, pulse iniciar → valido on the next edge, periodo=1, erro=10.
- Zero lockup: seed 0x01, switch sequencia to 0x00 three cycles after start → periodo=3, erro=01.
- Timeout: MAX_CICLOS=16, sequencia = free-running 8-bit counter starting 0x10, iniciar → periodo=16, erro=11 after 16 edges.
- Reset mid-COUNT: reset=0 at edge 100 of a maximal run → next state IDLE, valido=0, ocupado=0, periodo=0, erro=00. iniciar is ignored while reset=0; a fresh start afterwards reports 255.
- Handshake: in DONE, hold ack=0 for 10 cycles → valido, periodo and erro stable. Assert iniciar=1 simultaneously → no effect. Assert ack=1 for one cycle → valido=0 next edge, state IDLE.
